cci_mpf_edge_pwrite_merge: RTL and testbench

// FIU-side write-data heap merge stage. Consumes partial-write update requests

---
 rtl/cci_mpf_edge_pwrite_merge.sv | 162 ++++++++++++++++
 tb/tb_cci_mpf_edge_pwrite_merge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_edge_pwrite_merge.sv
// Write-data heap with a 3-stage byte-merge read-modify-write pipeline.
// Merges forward through in-flight and recently committed writes, so consecutive merges to one line compose.
module cci_mpf_edge_pwrite_merge #(
  parameter  int N_WRITE_HEAP_ENTRIES = 128,
  parameter  int N_CL_PER_ENTRY       = 4,
  parameter  int DATA_W               = 512,
  localparam int IDX_W                = $clog2(N_WRITE_HEAP_ENTRIES),
  localparam int CL_W                 = 2,
  localparam int MASK_W               = DATA_W / 8,
  localparam int ADDR_W               = IDX_W + CL_W,
  localparam int DEPTH                = N_WRITE_HEAP_ENTRIES * N_CL_PER_ENTRY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CL_W-1:0]   wr_clNum,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [CL_W-1:0]   upd_clNum,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [MASK_W-1:0] upd_mask,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [CL_W-1:0]   rd_clNum,
  output logic              rd_rdy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mrg_done,
  output logic [IDX_W-1:0]  mrg_done_idx,
  output logic [CL_W-1:0]   mrg_done_clNum
);

  // Handshake: a rd/wr request transfers in a cycle where its enable and its
  // ready are both high; the source holds the request stable until then.
  // upd_en has no ready and always transfers.

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q1, r_ram_q2;

  logic              r_s1_valid, r_s2_valid, r_s3_valid;
  logic [ADDR_W-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
  logic [DATA_W-1:0] r_s1_data, r_s2_data, r_s3_data;
  logic [MASK_W-1:0] r_s1_mask, r_s2_mask;

  logic              r_h1_valid, r_h2_valid;
  logic [ADDR_W-1:0] r_h1_addr, r_h2_addr;
  logic [DATA_W-1:0] r_h1_data, r_h2_data;

  logic              r_rd_v1, r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [ADDR_W-1:0] w_upd_addr, w_rd_addr, w_wr_addr;
  logic              w_rd_hit, w_wr_hit, w_rd_acc, w_wr_acc;
  logic [ADDR_W-1:0] w_ram_raddr, w_ram_waddr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata, w_old, w_merged;

  assign w_upd_addr = {upd_idx, upd_clNum};
  assign w_rd_addr  = {rd_idx, rd_clNum};
  assign w_wr_addr  = {wr_idx, wr_clNum};

  assign w_rd_hit = (r_s1_valid && (r_s1_addr == w_rd_addr)) ||
                    (r_s2_valid && (r_s2_addr == w_rd_addr)) ||
                    (r_s3_valid && (r_s3_addr == w_rd_addr));
  assign w_wr_hit = (r_s1_valid && (r_s1_addr == w_wr_addr)) ||
                    (r_s2_valid && (r_s2_addr == w_wr_addr)) ||
                    (r_s3_valid && (r_s3_addr == w_wr_addr));

  assign rd_rdy   = !upd_en && !w_rd_hit;
  assign wr_rdy   = !r_s3_valid;
  assign w_rd_acc = rd_en && rd_rdy;
  assign w_wr_acc = wr_en && wr_rdy;

  assign w_ram_raddr = upd_en ? w_upd_addr : w_rd_addr;
  assign w_ram_we    = r_s3_valid || w_wr_acc;
  assign w_ram_waddr = r_s3_valid ? r_s3_addr : w_wr_addr;
  assign w_ram_wdata = r_s3_valid ? r_s3_data : wr_data;

  // Heap RAM: read-before-write, two-cycle read latency, contents not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_waddr] <= w_ram_wdata;
    r_ram_q1 <= r_mem[w_ram_raddr];
    r_ram_q2 <= r_ram_q1;
  end

  // The s2 RAM value predates writes of the last two cycles and of this cycle;
  // patch it from the youngest matching write.
  always_comb begin
    w_old = r_ram_q2;
    if (r_h2_valid && (r_h2_addr == r_s2_addr)) w_old = r_h2_data;
    if (r_h1_valid && (r_h1_addr == r_s2_addr)) w_old = r_h1_data;
    if (w_ram_we && (w_ram_waddr == r_s2_addr)) w_old = w_ram_wdata;
  end

  always_comb begin
    w_merged = '0;
    for (int i = 0; i < MASK_W; i++) begin
      w_merged[i*8 +: 8] = r_s2_mask[i] ? r_s2_data[i*8 +: 8] : w_old[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s1_mask  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
      r_s2_mask  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_addr  <= '0;
      r_s3_data  <= '0;
      r_h1_valid <= 1'b0;
      r_h1_addr  <= '0;
      r_h1_data  <= '0;
      r_h2_valid <= 1'b0;
      r_h2_addr  <= '0;
      r_h2_data  <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_s1_valid <= upd_en;
      r_s1_addr  <= w_upd_addr;
      r_s1_data  <= upd_data;
      r_s1_mask  <= upd_mask;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_s2_data  <= r_s1_data;
      r_s2_mask  <= r_s1_mask;
      r_s3_valid <= r_s2_valid;
      r_s3_addr  <= r_s2_addr;
      r_s3_data  <= w_merged;
      r_h1_valid <= w_ram_we;
      r_h1_addr  <= w_ram_waddr;
      r_h1_data  <= w_ram_wdata;
      r_h2_valid <= r_h1_valid;
      r_h2_addr  <= r_h1_addr;
      r_h2_data  <= r_h1_data;
      r_rd_v1    <= w_rd_acc;
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) r_rd_data <= r_ram_q1;
    end
  end

  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign mrg_done       = r_s3_valid;
  assign mrg_done_idx   = r_s3_addr[ADDR_W-1:CL_W];
  assign mrg_done_clNum = r_s3_addr[CL_W-1:0];

`ifndef SYNTHESIS
  // Writing a line that still has a merge in flight would be silently overwritten.
  a_no_wr_during_merge : assert property (@(posedge clk) disable iff (reset) w_wr_acc |-> !w_wr_hit);
`endif

endmodule

// File: tb/tb_cci_mpf_edge_pwrite_merge.sv
// Bench for cci_mpf_edge_pwrite_merge: directed scenarios then random traffic,
// checked against a line-addressed heap model applied in transaction order.
module tb_cci_mpf_edge_pwrite_merge;
  localparam int IDX_W  = 7;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en, upd_en, rd_en;
  logic [IDX_W-1:0]  wr_idx, upd_idx, rd_idx;
  logic [1:0]        wr_clNum, upd_clNum, rd_clNum;
  logic [DATA_W-1:0] wr_data, upd_data;
  logic [MASK_W-1:0] upd_mask;
  logic              wr_rdy, rd_rdy, rd_valid, mrg_done;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  mrg_done_idx;
  logic [1:0]        mrg_done_clNum;

  cci_mpf_edge_pwrite_merge dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_clNum(wr_clNum), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_clNum(upd_clNum), .upd_data(upd_data), .upd_mask(upd_mask),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_clNum(rd_clNum), .rd_rdy(rd_rdy),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mrg_done(mrg_done), .mrg_done_idx(mrg_done_idx), .mrg_done_clNum(mrg_done_clNum)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  logic [DATA_W-1:0] ref_heap [512];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_due_q[$];
  logic [8:0]        mrg_q[$];
  int                mrg_due_q[$];
  logic [8:0]        pend_addr_q[$];
  int                pend_cyc_q[$];
  logic [DATA_W-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < MASK_W; i++) v[i*8 +: 8] = m[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    return v;
  endfunction

  // A merge issued in cycle t occupies the pipeline during cycles t+1..t+3.
  function automatic bit addr_pending(input logic [8:0] a, input int now);
    for (int i = 0; i < pend_addr_q.size(); i++)
      if (pend_addr_q[i] == a && pend_cyc_q[i] >= now - 3 && pend_cyc_q[i] <= now - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit s3_busy(input int now);
    for (int i = 0; i < pend_cyc_q.size(); i++)
      if (pend_cyc_q[i] == now - 3) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      if (mrg_due_q.size() > 0 && mrg_due_q[0] == cyc) begin
        check("mrg_done", mrg_done, 1'b1);
        check("mrg_done_addr", {mrg_done_idx, mrg_done_clNum}, mrg_q[0]);
        void'(mrg_q.pop_front());
        void'(mrg_due_q.pop_front());
      end else begin
        check("mrg_done_idle", mrg_done, 1'b0);
      end
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        check("rd_valid", rd_valid, 1'b1);
        check("rd_data", rd_data, exp_q[0]);
        last_rd = exp_q[0];
        void'(exp_q.pop_front());
        void'(exp_due_q.pop_front());
      end else begin
        check("rd_valid_idle", rd_valid, 1'b0);
        check("rd_data_hold", rd_data, last_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit u, input logic [8:0] ua, input logic [DATA_W-1:0] ud,
      input logic [MASK_W-1:0] um, input bit r, input logic [8:0] ra,
      input bit w, input logic [8:0] wa, input logic [DATA_W-1:0] wd, input bit model_upd,
      output bit r_acc, output bit w_acc, output int at_cyc);
    bit exp_rrdy, exp_wrdy;
    @(negedge clk);
    upd_en = u;  upd_idx = ua[8:2]; upd_clNum = ua[1:0]; upd_data = ud; upd_mask = um;
    rd_en  = r;  rd_idx  = ra[8:2]; rd_clNum  = ra[1:0];
    wr_en  = w;  wr_idx  = wa[8:2]; wr_clNum  = wa[1:0]; wr_data = wd;
    #1;
    while (pend_cyc_q.size() > 0 && pend_cyc_q[0] < cyc - 3) begin
      void'(pend_cyc_q.pop_front());
      void'(pend_addr_q.pop_front());
    end
    exp_rrdy = !u && !addr_pending(ra, cyc);
    exp_wrdy = !s3_busy(cyc);
    check("rd_rdy", rd_rdy, exp_rrdy);
    check("wr_rdy", wr_rdy, exp_wrdy);
    r_acc  = r && exp_rrdy;
    w_acc  = w && exp_wrdy;
    at_cyc = cyc;
    if (r_acc) begin
      exp_q.push_back(ref_heap[ra]);
      exp_due_q.push_back(cyc + 2);
    end
    if (w_acc) ref_heap[wa] = wd;
    if (u) begin
      pend_addr_q.push_back(ua);
      pend_cyc_q.push_back(cyc);
      if (model_upd) begin
        ref_heap[ua] = byte_merge(ref_heap[ua], ud, um);
        mrg_q.push_back(ua);
        mrg_due_q.push_back(cyc + 3);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit ra, wa;
    int c;
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1, ra, wa, c);
  endtask

  task automatic upd1(input logic [8:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m,
      input bit model_upd, output int at_cyc);
    bit ra, wa;
    step(1'b1, a, d, m, 1'b0, '0, 1'b0, '0, '0, model_upd, ra, wa, at_cyc);
  endtask

  task automatic write_until(input logic [8:0] a, input logic [DATA_W-1:0] d, output int at_cyc);
    bit ra, wa;
    int tries = 0;
    do begin
      step(1'b0, '0, '0, '0, 1'b0, a, 1'b1, a, d, 1'b1, ra, wa, at_cyc);
      tries++;
    end while (!wa && tries < 20);
    check("wr_accept", wa, 1'b1);
  endtask

  task automatic read_until(input logic [8:0] a, output int at_cyc);
    bit ra, wa;
    int tries = 0;
    do begin
      step(1'b0, '0, '0, '0, 1'b1, a, 1'b0, '0, '0, 1'b1, ra, wa, at_cyc);
      tries++;
    end while (!ra && tries < 20);
    check("rd_accept", ra, 1'b1);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    upd_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete(); exp_due_q.delete();
    mrg_q.delete(); mrg_due_q.delete();
    pend_addr_q.delete(); pend_cyc_q.delete();
    last_rd = '0;
    repeat (hold) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] a, b;
    int c0, c1;
    bit hold_r, hold_w, r_acc, w_acc, u;
    logic [8:0] hra, hwa, ua;
    logic [DATA_W-1:0] hwd;

    reset = 1'b1;
    upd_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    upd_idx = '0; upd_clNum = '0; upd_data = '0; upd_mask = '0;
    rd_idx = '0; rd_clNum = '0; wr_idx = '0; wr_clNum = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, '0);
    check("reset_mrg_done", mrg_done, 1'b0);
    check("reset_mrg_addr", {mrg_done_idx, mrg_done_clNum}, '0);
    check("reset_rd_rdy", rd_rdy, 1'b1);
    check("reset_wr_rdy", wr_rdy, 1'b1);
    #2 reset = 1'b0;
    mon_on = 1'b1;

    // single merge over a written line
    a = {7'd5, 2'd0};
    write_until(a, {64{8'hAA}}, c0);
    upd1(a, {64{8'h55}}, 64'h0000_0000_0000_00FF, 1'b1, c0);
    idle(3);
    read_until(a, c0);
    idle(2);
    check("t1_expected_line", ref_heap[a], {{504{1'b0}} | {{56{8'hAA}}, {8{8'h55}}}});

    // back-to-back merges to one line compose
    a = {7'd3, 2'd1};
    write_until(a, '0, c0);
    upd1(a, {64{8'h11}}, 64'h0F, 1'b1, c0);
    upd1(a, {64{8'h22}}, 64'hF0, 1'b1, c0);
    idle(3);
    read_until(a, c0);
    idle(2);

    // upd has priority over rd; a merging line stalls reads until after mrg_done
    a = {7'd7, 2'd2};
    b = {7'd6, 2'd3};
    write_until(a, rnd_line(), c0);
    write_until(b, rnd_line(), c0);
    step(1'b1, a, rnd_line(), 64'hFFFF_0000_FFFF_0000, 1'b1, b, 1'b0, '0, '0, 1'b1, r_acc, w_acc, c0);
    read_until(b, c1);
    check("t3_rd_next_cycle", c1 - c0, 1);
    upd1(a, rnd_line(), {$urandom(), $urandom()}, 1'b1, c0);
    read_until(a, c1);
    check("t3_stall_len", c1 - c0, 4);
    idle(2);

    // wr blocked while a merge writes back, held write commits next cycle
    a = {7'd8, 2'd0};
    b = {7'd9, 2'd0};
    write_until(a, rnd_line(), c0);
    upd1(a, rnd_line(), {$urandom(), $urandom()}, 1'b1, c0);
    idle(2);
    write_until(b, rnd_line(), c1);
    check("t4_wr_hold_len", c1 - c0, 4);
    read_until(b, c0);
    idle(3);

    // reset with merges in s1 and s2 drops them; heap keeps pre-merge data
    a = {7'd11, 2'd0};
    write_until(a, rnd_line(), c0);
    idle(1);
    upd1(a, {64{8'hEE}}, '1, 1'b0, c0);
    upd1(a, {64{8'hDD}}, '1, 1'b0, c0);
    do_reset(2);
    idle(3);
    read_until(a, c0);
    idle(3);

    // corner slots, every line independent
    for (int cl = 0; cl < 4; cl++) begin
      write_until({7'd0, 2'(cl)}, rnd_line(), c0);
      write_until({7'd127, 2'(cl)}, rnd_line(), c0);
    end
    for (int cl = 0; cl < 4; cl++) begin
      read_until({7'd0, 2'(cl)}, c0);
      read_until({7'd127, 2'(cl)}, c0);
    end
    idle(3);

    // random traffic: merges on pool A, writes on pool B, reads on both
    for (int i = 0; i < 4; i++)
      for (int cl = 0; cl < 4; cl++) begin
        write_until({7'(10 + i), 2'(cl)}, rnd_line(), c0);
        write_until({7'(20 + i), 2'(cl)}, rnd_line(), c0);
      end
    hold_r = 1'b0; hold_w = 1'b0;
    hra = '0; hwa = '0; hwd = '0;
    for (int n = 0; n < 400; n++) begin
      u  = ($urandom_range(0, 2) == 0);
      ua = {7'(10 + $urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (!hold_r && $urandom_range(0, 1) == 1) begin
        hold_r = 1'b1;
        hra = {7'(($urandom_range(0, 1) == 1 ? 10 : 20) + $urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      end
      if (!hold_w && $urandom_range(0, 2) == 0) begin
        hold_w = 1'b1;
        hwa = {7'(20 + $urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        hwd = rnd_line();
      end
      step(u, ua, rnd_line(), {$urandom(), $urandom()}, hold_r, hra, hold_w, hwa, hwd, 1'b1,
           r_acc, w_acc, c0);
      if (r_acc) hold_r = 1'b0;
      if (w_acc) hold_w = 1'b0;
    end
    idle(6);
    check("drain_reads", exp_q.size(), 0);
    check("drain_merges", mrg_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
